load_store_unit: RTL

- Data-memory side of the core. It consumes the memory controls produced by instruction decode: MemRead, the 4-bit MemWrite byte mask, MemReadSize and MemReadSigned.
- It issues a single word-aligned transaction on a req/ack data bus, shifting byte lanes for stores and extracting plus sign- or zero-extending loads.
- It stalls the pipeline while a transaction is outstanding, sitting between the ALU/address stage and writeback.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit state, fault, size and store-mask definitions
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ALIGN   = 2'b01,
    F_BUS     = 2'b10,
    F_TIMEOUT = 2'b11
  } lsu_fault_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Unshifted byte-enable pattern for a load of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return MASK_B;
      SZ_HALF: return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts a byte/half/word from a read word and sign- or zero-extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    data     = rdata;
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-transaction data-memory access unit with pipeline stall
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic [3:0]  MemWrite,
  input  logic [1:0]  MemReadSize,
  input  logic        MemReadSigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  lsu_state_t  state, state_next;
  logic [7:0]  cnt;
  logic        op_load, op_signed;
  logic [1:0]  op_size, op_off;
  logic [1:0]  req_size;
  logic [3:0]  req_mask;
  logic        mask_ok, bad_req, accept, timeout_hit;
  logic [31:0] rdata_aligned;

  // Stores carry their width in the mask; loads carry it in MemReadSize.
  always_comb begin
    req_size = SZ_BYTE;
    req_mask = MemWrite;
    if (MemRead) begin
      req_size = MemReadSize;
      req_mask = size_mask(MemReadSize);
    end else if (MemWrite == MASK_W) begin
      req_size = SZ_WORD;
    end else if (MemWrite == MASK_H) begin
      req_size = SZ_HALF;
    end
    mask_ok = (MemWrite == MASK_NONE) || (MemWrite == MASK_B) ||
              (MemWrite == MASK_H) || (MemWrite == MASK_W);
    bad_req = (MemRead && MemWrite != MASK_NONE) || !mask_ok ||
              (MemRead && MemReadSize == 2'd3) ||
              (req_size == SZ_HALF && addr[0]) ||
              (req_size == SZ_WORD && addr[1:0] != 2'b00);
    accept      = (state == IDLE) && req_valid && (MemRead || MemWrite != MASK_NONE);
    timeout_hit = (state == BUS) && !mem_ack && (cnt + 8'd1 == TO_LIMIT);
  end

  assign stall = accept || (state == BUS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad_req ? RESP : BUS;
      BUS:     if (mem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  load_align u_align (
    .rdata    (mem_rdata),
    .offset   (op_off),
    .size     (op_size),
    .sign_ext (op_signed),
    .data     (rdata_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 8'd0;
      op_load    <= 1'b0;
      op_signed  <= 1'b0;
      op_size    <= SZ_BYTE;
      op_off     <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      load_valid <= 1'b0;
      load_data  <= 32'd0;
      fault      <= F_NONE;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt       <= 8'd0;
          op_load   <= MemRead;
          op_signed <= MemReadSigned;
          op_size   <= req_size;
          op_off    <= addr[1:0];
          if (bad_req) begin
            fault <= F_ALIGN;
            done  <= 1'b1;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= !MemRead;
            mem_be   <= req_mask << addr[1:0];
            mem_addr <= {addr[31:2], 2'b00};
            case (MemWrite)
              MASK_B:  mem_wdata <= {4{wdata[7:0]}};
              MASK_H:  mem_wdata <= {2{wdata[15:0]}};
              default: mem_wdata <= wdata;
            endcase
          end
        end
        BUS: begin
          cnt <= cnt + 8'd1;
          // An ack arriving on the timeout cycle still completes the transfer.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            fault   <= mem_err ? F_BUS : F_NONE;
            done    <= 1'b1;
            if (op_load && !mem_err) begin
              load_data  <= rdata_aligned;
              load_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            fault   <= F_TIMEOUT;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
